mips_mem_arbiter: RTL
=====================

MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, giving the consecutive data grants allowed while fetch waits (legal 1..15).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port halted, input, 1, processor HALTED flag; when 1, fetch requests are not granted.
REQ-005 SHALL have port if_req, input, 1, instruction-fetch request; held until if_gnt.
REQ-006 SHALL have port if_addr, input, 32, fetch word address.
REQ-007 SHALL have port if_gnt, output, 1, one-cycle pulse when a fetch is accepted.
REQ-008 SHALL have port if_valid, output, 1, one-cycle pulse when if_rdata is new.
REQ-009 SHALL have port if_rdata, output, 32, fetched instruction word.
REQ-010 SHALL have port dm_req, input, 1, data-access request; held until dm_gnt.
REQ-011 SHALL have port dm_we, input, 1, 1 = store, 0 = load.
REQ-012 SHALL have port dm_addr, input, 32, data word address.
REQ-013 SHALL have port dm_wdata, input, 32, store data.
REQ-014 SHALL have port dm_gnt, output, 1, one-cycle pulse when a data access is accepted.
REQ-015 SHALL have port dm_valid, output, 1, one-cycle pulse on completion of a load or store.
REQ-016 SHALL have port dm_rdata, output, 32, load data.
REQ-017 SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, 32), mem_wdata (out, 32), for the shared single-port memory.
REQ-018 SHALL have ports mem_rdata (in, 32) and mem_ready (in, 1), memory read data and completion strobe.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY_IF, BUSY_DM.
REQ-020 In IDLE, SHALL sample requests each cycle; eligible fetch = if_req & ~halted.
REQ-021 Arbitration SHALL grant data over fetch, except when starve_cnt == STARVE_LIMIT and both are eligible, in which case fetch wins.
REQ-022 On accepting a request in cycle N, SHALL register addr/we/wdata and enter BUSY_x at edge N; the matching x_gnt SHALL be 1 for cycle N+1 only.
REQ-023 In BUSY_x, mem_en SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL be stable; mem_we SHALL be 0 in BUSY_IF.
REQ-024 When mem_ready is sampled 1 in BUSY_x, SHALL capture mem_rdata into x_rdata, pulse x_valid the following cycle, and return to IDLE.
REQ-025 Minimum request-to-valid latency SHALL be 2 cycles after grant (mem_ready in first busy cycle); back-to-back accesses SHALL be separated by exactly one IDLE cycle.
REQ-026 dm_valid SHALL pulse for stores as well as loads; dm_rdata SHALL be unchanged after a store.
REQ-027 if_rdata/dm_rdata SHALL hold their value until the next valid pulse of the same port.
REQ-028 starve_cnt (4-bit) SHALL increment on each data grant while if_req & ~halted, saturate at STARVE_LIMIT, and clear on a fetch grant or when fetch is not eligible in an IDLE cycle.
REQ-029 Requests arriving while BUSY SHALL be ignored until IDLE; no request SHALL be lost if held per REQ-005/REQ-010.
REQ-030 halted rising during BUSY_IF SHALL NOT abort the fetch; it completes and if_valid pulses.
REQ-031 mem_ready while IDLE SHALL be ignored.

Reset
REQ-032 When rst is 1 at an edge, SHALL enter IDLE, clear starve_cnt, and drive all outputs 0 (including rdata and mem_* buses) the next cycle.
REQ-033 rst during BUSY_x SHALL abort the access with no x_valid pulse; mem_en SHALL drop the cycle after the reset edge.

Verification
REQ-034 Single fetch: if_req=1, if_addr=0x5, mem_ready one cycle after grant, mem_rdata=0x00222000 -> if_gnt pulse, mem_addr=0x5, mem_we=0, if_valid pulse, if_rdata=0x00222000.
REQ-035 Simultaneous: if_req=dm_req=1, starve_cnt=0 -> dm_gnt first; if_gnt after the one-cycle IDLE following dm_valid.
REQ-036 Starvation: if_req held, dm_req held continuously, STARVE_LIMIT=3 -> three dm_gnt pulses, then if_gnt, then dm_gnt again.
REQ-037 Store: dm_we=1, dm_addr=0x10, dm_wdata=0xA -> mem_we=1, mem_wdata=0xA, dm_valid pulse, dm_rdata unchanged.
REQ-038 Halt: halted=1, if_req=1 for 10 cycles -> no if_gnt, mem_en=0; dm_req still granted.
REQ-039 Reset mid-access: rst=1 in second BUSY_DM cycle with mem_ready=0 -> no dm_valid, mem_en=0 next cycle, outputs 0, state IDLE.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter
//   Arbitrates one shared single-port memory between the instruction-fetch
//   port (if_*) and the data port (dm_*) of a MIPS-style core. Data accesses
//   normally win; a 4-bit starvation counter forces a fetch grant once
//   STARVE_LIMIT consecutive data grants have been issued while a fetch was
//   waiting. Every access is IDLE -> BUSY_x -> IDLE, so back-to-back accesses
//   are separated by exactly one IDLE cycle.
//
// Ports
//   clk, rst           : system clock, synchronous active-high reset
//   halted             : core halted; fetch requests are not granted
//   if_req/if_addr     : fetch request (held until if_gnt) and word address
//   if_gnt/if_valid    : one-cycle accept / completion pulses
//   if_rdata           : fetched word, held until the next if_valid
//   dm_req/dm_we       : data request (held until dm_gnt), 1 = store
//   dm_addr/dm_wdata   : data word address and store data
//   dm_gnt/dm_valid    : one-cycle accept / completion pulses (loads+stores)
//   dm_rdata           : load data, held until the next load completes
//   mem_en/mem_we/mem_addr/mem_wdata : shared memory command, all registered
//   mem_rdata/mem_ready: memory read data and completion strobe
// ---------------------------------------------------------------------------
module mips_mem_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halted,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_r;
  state_t      next_state_s;
  logic [3:0]  starve_cnt_r;
  logic [3:0]  starve_nxt_s;
  logic        if_elig_s;
  logic        grant_if_s;
  logic        grant_dm_s;
  logic        done_if_s;
  logic        done_dm_s;

  logic        if_gnt_r;
  logic        if_valid_r;
  logic [31:0] if_rdata_r;
  logic        dm_gnt_r;
  logic        dm_valid_r;
  logic [31:0] dm_rdata_r;
  logic        mem_en_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;

  assign if_elig_s = if_req & ~halted;

  // State and starvation-counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      starve_cnt_r <= 4'd0;
    end else begin
      state_r      <= next_state_s;
      starve_cnt_r <= starve_nxt_s;
    end
  end

  // Arbitration, next-state and starvation-counter update.
  always_comb begin
    next_state_s = state_r;
    starve_nxt_s = starve_cnt_r;
    grant_if_s   = 1'b0;
    grant_dm_s   = 1'b0;
    done_if_s    = 1'b0;
    done_dm_s    = 1'b0;
    case (state_r)
      IDLE: begin
        // Data wins unless fetch has waited through LIMIT data grants.
        if (dm_req && (!if_elig_s || (starve_cnt_r != LIMIT))) begin
          grant_dm_s   = 1'b1;
          next_state_s = BUSY_DM;
          if (!if_elig_s) begin
            starve_nxt_s = 4'd0;
          end else if (starve_cnt_r < LIMIT) begin
            starve_nxt_s = starve_cnt_r + 4'd1;
          end else begin
            starve_nxt_s = starve_cnt_r;
          end
        end else if (if_elig_s) begin
          grant_if_s   = 1'b1;
          next_state_s = BUSY_IF;
          starve_nxt_s = 4'd0;
        end else begin
          // Nothing granted and fetch not eligible: the wait streak is broken.
          starve_nxt_s = 4'd0;
        end
      end
      BUSY_IF: begin
        if (mem_ready) begin
          done_if_s    = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = BUSY_IF;
        end
      end
      BUSY_DM: begin
        if (mem_ready) begin
          done_dm_s    = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = BUSY_DM;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Registered port outputs and the latched memory command.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_gnt_r    <= 1'b0;
      if_valid_r  <= 1'b0;
      if_rdata_r  <= 32'd0;
      dm_gnt_r    <= 1'b0;
      dm_valid_r  <= 1'b0;
      dm_rdata_r  <= 32'd0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
    end else begin
      if_gnt_r   <= grant_if_s;
      dm_gnt_r   <= grant_dm_s;
      if_valid_r <= done_if_s;
      dm_valid_r <= done_dm_s;
      if (done_if_s) begin
        if_rdata_r <= mem_rdata;
      end
      // A completing store leaves the load data untouched.
      if (done_dm_s && !mem_we_r) begin
        dm_rdata_r <= mem_rdata;
      end
      if (grant_dm_s) begin
        mem_en_r    <= 1'b1;
        mem_we_r    <= dm_we;
        mem_addr_r  <= dm_addr;
        mem_wdata_r <= dm_wdata;
      end else if (grant_if_s) begin
        mem_en_r    <= 1'b1;
        mem_we_r    <= 1'b0;
        mem_addr_r  <= if_addr;
        mem_wdata_r <= 32'd0;
      end else if (done_if_s || done_dm_s) begin
        mem_en_r    <= 1'b0;
        mem_we_r    <= 1'b0;
      end
    end
  end

  assign if_gnt    = if_gnt_r;
  assign if_valid  = if_valid_r;
  assign if_rdata  = if_rdata_r;
  assign dm_gnt    = dm_gnt_r;
  assign dm_valid  = dm_valid_r;
  assign dm_rdata  = dm_rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule
